// File: rtl/lcd_text_pkg.sv
// Shared encodings and constants for the LCD text feeder.
// LCD_TEXT_NEWLINE_PAD_EN adds the newline padding state.
package lcd_text_pkg;
  localparam logic [7:0]  ASCII_NL = 8'h0A;
  localparam logic [7:0]  ASCII_SP = 8'h20;
  localparam int unsigned COL_W    = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STROBE,
    ST_RELEASE,
    ST_GAP
`ifdef LCD_TEXT_NEWLINE_PAD_EN
    , ST_PAD
`endif
  } state_e;
endpackage

// File: rtl/lcd_text_feeder_char_fifo.sv
// DEPTH x 8 synchronous FIFO; a push while full is accepted only alongside a pop.
module char_fifo
  import lcd_text_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic            full,
  output logic [ADDR_W:0] count
);
  localparam int CNT_W = ADDR_W + 1;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign push    = wr_en && (!full || rd_en);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = push  ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/lcd_text_feeder.sv
// Buffers ASCII bytes and strobes them one at a time into the HD44780 controller.
// Define LCD_TEXT_NEWLINE_PAD_EN to expand 8'h0A into spaces up to the next line start.
module lcd_text_feeder
  import lcd_text_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HOLD_CYCLES = 80,
  parameter int GAP_CYCLES  = 8,
  parameter int LINE_LEN    = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic [ADDR_W:0]  count,
  output logic             overflow,
  output logic             busy,
  output logic [COL_W-1:0] col,
  input  logic             lcd_ready,
  output logic [7:0]       lcd_data,
  output logic             lcd_ex
);
  localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(2 * LINE_LEN - 1);
`ifdef LCD_TEXT_NEWLINE_PAD_EN
  localparam logic [COL_W-1:0] COL_LINE = COL_W'(LINE_LEN);
`endif

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       data_q, data_d;
  logic             ex_q, ex_d;
  logic             ovf_q, ovf_d;
`ifdef LCD_TEXT_NEWLINE_PAD_EN
  logic             pad_q, pad_d;
`endif
  logic             pop;
  logic [7:0]       head;

  assign pop = (state_q == ST_LOAD);

  char_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (pop),
    .rd_data(head),
    .full   (full),
    .count  (count)
  );

  assign lcd_ex   = ex_q;
  assign lcd_data = data_q;
  assign col      = col_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    col_d   = col_q;
    data_d  = data_q;
    ex_d    = ex_q;
    ovf_d   = ovf_q | (wr_en && full && !pop);
`ifdef LCD_TEXT_NEWLINE_PAD_EN
    pad_d   = pad_q;
`endif
    case (state_q)
      ST_IDLE: if (lcd_ready && count != '0) state_d = ST_LOAD;
      ST_LOAD: begin
`ifdef LCD_TEXT_NEWLINE_PAD_EN
        if (head == ASCII_NL) begin
          pad_d   = 1'b1;
          state_d = ST_PAD;
        end else
`endif
        begin
          data_d  = head;
          ex_d    = 1'b0;
          timer_d = HOLD_LD;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (timer_q == '0) begin
          ex_d    = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_RELEASE: begin
        col_d   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
        timer_d = GAP_LD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (timer_q == '0) begin
`ifdef LCD_TEXT_NEWLINE_PAD_EN
          state_d = pad_q ? ST_PAD : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
`ifdef LCD_TEXT_NEWLINE_PAD_EN
      // PAD doubles as the load cycle for each padding space.
      ST_PAD: begin
        if (col_q == '0 || col_q == COL_LINE) begin
          pad_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          data_d  = ASCII_SP;
          ex_d    = 1'b0;
          timer_d = HOLD_LD;
          state_d = ST_STROBE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      col_q   <= '0;
      data_q  <= ASCII_SP;
      ex_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef LCD_TEXT_NEWLINE_PAD_EN
      pad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      col_q   <= col_d;
      data_q  <= data_d;
      ex_q    <= ex_d;
      ovf_q   <= ovf_d;
`ifdef LCD_TEXT_NEWLINE_PAD_EN
      pad_q   <= pad_d;
`endif
    end
  end
endmodule

// File: tb/tb_lcd_text_feeder.sv
// Self-checking bench for lcd_text_feeder: timeline reference model plus directed checks.
module tb_lcd_text_feeder;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int HOLD     = 80;
  localparam int GAP      = 8;
  localparam int LINE_LEN = 40;
  localparam int IDLE_PH  = HOLD + GAP + 2;
`ifdef LCD_TEXT_NEWLINE_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            lcd_ready = 1'b0;
  logic            full, overflow, busy, lcd_ex;
  logic [ADDR_W:0] count;
  logic [6:0]      col;
  logic [7:0]      lcd_data;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_text_feeder #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .LINE_LEN(LINE_LEN)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .count(count),
    .overflow(overflow), .busy(busy), .col(col), .lcd_ready(lcd_ready),
    .lcd_data(lcd_data), .lcd_ex(lcd_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_ph counts cycles since the current character's load cycle.
  logic [7:0]  mq[$];
  int unsigned m_ph = IDLE_PH;
  int unsigned m_col = 0;
  int unsigned nph;
  bit          m_virt = 1'b0, m_pad = 1'b0, m_ovf = 1'b0, start;
  logic [7:0]  m_data = 8'h20;
  logic [7:0]  pb;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_ph = IDLE_PH; m_virt = 1'b0; m_pad = 1'b0; m_ovf = 1'b0;
      m_col = 0; m_data = 8'h20;
    end else begin
      start = (m_ph >= IDLE_PH) && lcd_ready && (mq.size() != 0);
      nph   = (m_ph < IDLE_PH) ? m_ph + 1 : IDLE_PH;
      if (m_ph == 0) begin
        if (!m_virt) begin
          pb = (mq.size() != 0) ? mq.pop_front() : 8'hxx;
          if (PAD_EN && pb == 8'h0A) begin nph = 0; m_virt = 1'b1; m_pad = 1'b1; end
          else m_data = pb;
        end else if (m_col % LINE_LEN == 0) begin
          m_pad = 1'b0; nph = IDLE_PH;
        end else begin
          m_data = 8'h20;
        end
      end
      if (m_ph == HOLD + 1) m_col = (m_col == 2 * LINE_LEN - 1) ? 0 : m_col + 1;
      if (m_ph == HOLD + GAP + 1 && m_pad) begin nph = 0; m_virt = 1'b1; end
      if (start) begin nph = 0; m_virt = 1'b0; end
      if (wr_en) begin
        if (mq.size() < DEPTH) mq.push_back(wr_data);
        else m_ovf = 1'b1;
      end
      m_ph = nph;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("lcd_ex",   lcd_ex,   (m_ph >= 1 && m_ph <= HOLD) ? 0 : 1);
      check("lcd_data", lcd_data, m_data);
      check("busy",     busy,     m_ph < IDLE_PH);
      check("col",      col,      m_col);
      check("count",    count,    mq.size());
      check("full",     full,     mq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
    end
  end

  // Record every byte presented on a falling strobe, with the column at that moment.
  logic [7:0] cap[$];
  logic [6:0] capcol[$];
  logic       prev_ex = 1'b1;
  always @(negedge clk) begin
    if (!rst) prev_ex = 1'b1;
    else begin
      if (prev_ex && !lcd_ex) begin cap.push_back(lcd_data); capcol.push_back(col); end
      prev_ex = lcd_ex;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    wr_en = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cap.delete(); capcol.delete();
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(count == 0 && busy == 1'b0) && n < budget);
    check({name, "_timeout"}, n < budget, 1);
  endtask

  logic [7:0] expl[$];
  int n;
  int sent;
  int sp;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_ex", lcd_ex, 1); check("rst_data", lcd_data, 8'h20); check("rst_count", count, 0);
    check("rst_full", full, 0); check("rst_ovf", overflow, 0); check("rst_busy", busy, 0);
    check("rst_col", col, 0);
    rst = 1'b1;

    // Single character latency, hold width, column advance
    @(negedge clk);
    lcd_ready = 1'b1;
    push(8'h41);
    check("lat_c1", lcd_ex, 1);
    @(negedge clk); check("lat_c2", lcd_ex, 1);
    @(negedge clk); check("lat_c3", lcd_ex, 0); check("lat_data", lcd_data, 8'h41);
    n = 0;
    while (lcd_ex === 1'b0 && n < 200) begin n++; @(negedge clk); end
    check("hold_len", n, HOLD);
    wait_idle(100, "single");
    check("single_col", col, 1);

    // Reset in the middle of a strobe
    push(8'h43); push(8'h44); push(8'h45);
    n = 0;
    while (lcd_ex !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("mid_strobe_seen", lcd_ex, 0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_ex", lcd_ex, 1); check("async_count", count, 0); check("async_col", col, 0);
    check("async_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    cap.delete(); capcol.delete();
    repeat (300) @(negedge clk);
    check("post_rst_silent", cap.size(), 0);

    // Fill past capacity, then drain in order
    do_reset();
    lcd_ready = 1'b0;
    expl.delete();
    for (int i = 0; i < 17; i++) begin
      pb = 8'($urandom_range(8'h21, 8'h7E));
      if (i < DEPTH) expl.push_back(pb);
      push(pb);
    end
    check("fill_full", full, 1); check("fill_count", count, 16); check("fill_ovf", overflow, 1);
    lcd_ready = 1'b1;
    wait_idle(2500, "drain");
    check("drain_len", cap.size(), 16);
    for (int i = 0; i < 16; i++) if (i < cap.size()) check("drain_order", cap[i], expl[i]);
    check("ovf_sticky", overflow, 1);

    // Push and pop in the same cycle while full
    do_reset();
    lcd_ready = 1'b0;
    expl.delete();
    for (int i = 0; i < DEPTH; i++) begin
      pb = 8'($urandom_range(8'h21, 8'h7E)); expl.push_back(pb); push(pb);
    end
    lcd_ready = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("load_seen", busy, 1);
    pb = 8'h5A; expl.push_back(pb);
    push(pb);
    check("pp_count", count, 16); check("pp_ovf", overflow, 0); check("pp_full", full, 1);
    wait_idle(2500, "pp_drain");
    check("pp_len", cap.size(), 17);
    for (int i = 0; i < 17; i++) if (i < cap.size()) check("pp_order", cap[i], expl[i]);

    // Randomized traffic
    do_reset();
    lcd_ready = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      wr_en = ($urandom_range(0, 24) == 0);
      wr_data = 8'($urandom_range(0, 255));
      if (PAD_EN && wr_data == 8'h0A) wr_data = 8'h0B;
      if ($urandom_range(0, 149) == 0) lcd_ready = ~lcd_ready;
      @(negedge clk);
    end
    wr_en = 1'b0; lcd_ready = 1'b1;
    wait_idle(3000, "rand");

    // Column wrap after 80 characters
    do_reset();
    lcd_ready = 1'b1;
    sent = 0; n = 0;
    while (sent < 80 && n < 9000) begin
      wr_en = (mq.size() < DEPTH - 1);
      wr_data = 8'($urandom_range(8'h21, 8'h7E));
      if (wr_en) sent++;
      @(negedge clk); n++;
    end
    wr_en = 1'b0;
    check("wrap_feed_timeout", n < 9000, 1);
    wait_idle(3000, "wrap");
    check("wrap_len", cap.size(), 80);
    check("wrap_col", col, 0);
    if (cap.size() == 80) check("wrap_last_col", capcol[79], 79);

    // Newline handling
    do_reset();
    lcd_ready = 1'b1;
    push(8'h78); push(8'h79); push(8'h7A);
    wait_idle(400, "nl_pre");
    check("nl_pre_col", col, 3);
    cap.delete(); capcol.delete();
    push(8'h0A); push(8'h42);
    wait_idle(5000, "nl");
    if (PAD_EN) begin
      check("pad_len", cap.size(), 38);
      sp = 0;
      for (int i = 0; i < 37; i++) if (i < cap.size() && cap[i] == 8'h20) sp++;
      check("pad_spaces", sp, 37);
      if (cap.size() == 38) begin
        check("pad_b", cap[37], 8'h42); check("pad_b_col", capcol[37], 40);
      end
      check("pad_col", col, 41);
    end else begin
      check("nl_len", cap.size(), 2);
      if (cap.size() == 2) begin
        check("nl_byte", cap[0], 8'h0A); check("nl_b", cap[1], 8'h42);
        check("nl_b_col", capcol[1], 4);
      end
      check("nl_col", col, 5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
